// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and FSM state type for the convolution stream source
//
// Purpose: default frame geometry, convolver output width and top FSM states.
// Ports:   none (package).

package conv_pkg;

   localparam int CONV_N = 128;                              // x frame length
   localparam int CONV_M = 32;                               // f frame length
   localparam int CONV_W = 8;                                // sample width
   localparam int W_Y    = 2*CONV_W + $clog2(CONV_M) + 1;    // convolver output width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      FIN  = 2'd2
   } state_e;

endpackage

// File: rtl/stream_chan_tx.sv
// rtl/stream_chan_tx.sv - one valid/ready transmit channel with its own frame buffer
//
// Purpose: holds LEN samples, replays them nframes times on a valid/ready stream.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   go                    restart: clear counters, latch nframes, present sample 0
//   nframes[7:0]          repeat count, latched on go
//   wr_en/wr_addr/wr_data buffer write port
//   m_data/m_valid/m_ready stream master
//   fin                   next-state of the fin flag (high once last sample has handshaken)

module stream_chan_tx #(
   parameter int LEN = 128,
   parameter int W   = 8,
   parameter int IW  = $clog2(LEN)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          go,
   input  logic [7:0]    nframes,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   output logic [W-1:0]  m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          fin
);

   logic [W-1:0]  buf_q [LEN];
   logic [IW-1:0] idx_q,   idx_d;
   logic [7:0]    frame_q, frame_d;
   logic [7:0]    nfr_q,   nfr_d;
   logic          valid_q, valid_d;
   logic [W-1:0]  data_q,  data_d;
   logic          fin_q,   fin_d;
   logic          hs;

   // Buffer is plain storage: no reset, contents survive resets and restarts.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         buf_q[wr_addr] <= wr_data;
      end
   end

   assign hs = valid_q & m_ready;

   // data_q is always preloaded with the next sample so there is no bubble at wrap.
   always_comb begin
      idx_d   = idx_q;
      frame_d = frame_q;
      nfr_d   = nfr_q;
      valid_d = valid_q;
      data_d  = data_q;
      fin_d   = fin_q;
      if (go) begin
         idx_d   = '0;
         frame_d = '0;
         nfr_d   = nframes;
         valid_d = 1'b1;
         data_d  = buf_q[0];
         fin_d   = 1'b0;
      end else if (hs) begin
         if (idx_q == IW'(LEN-1)) begin
            idx_d   = '0;
            frame_d = frame_q + 8'd1;
            if (frame_q + 8'd1 == nfr_q) begin
               valid_d = 1'b0;
               data_d  = '0;
               fin_d   = 1'b1;
            end else begin
               data_d  = buf_q[0];
            end
         end else begin
            idx_d  = idx_q + IW'(1);
            data_d = buf_q[idx_q + IW'(1)];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q   <= '0;
         frame_q <= '0;
         nfr_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         fin_q   <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         frame_q <= frame_d;
         nfr_q   <= nfr_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         fin_q   <= fin_d;
      end
   end

   assign m_data  = data_q;
   assign m_valid = valid_q;
   // Exported one cycle early so the top can pulse done right after the final handshake.
   assign fin     = fin_d;

endmodule

// File: rtl/conv_stream_src.sv
// rtl/conv_stream_src.sv - x/f frame stream source for the 1-D convolver
//
// Purpose: host-loaded x and f frames replayed nframes times on two independent streams.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   ld_valid/ld_ready/ld_sel/ld_addr/ld_data  host write port (IDLE only)
//   start, nframes[7:0]               transmit command, repeat count
//   busy, done                        high in SEND, one-cycle completion pulse
//   m_data_x/m_valid_x/m_ready_x      x stream master
//   m_data_f/m_valid_f/m_ready_f      f stream master

module conv_stream_src
   import conv_pkg::*;
#(
   parameter int N = CONV_N,
   parameter int M = CONV_M,
   parameter int W = CONV_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ld_valid,
   output logic                 ld_ready,
   input  logic                 ld_sel,
   input  logic [$clog2(N)-1:0] ld_addr,
   input  logic [W-1:0]         ld_data,
   input  logic                 start,
   input  logic [7:0]           nframes,
   output logic                 busy,
   output logic                 done,
   output logic [W-1:0]         m_data_x,
   output logic                 m_valid_x,
   input  logic                 m_ready_x,
   output logic [W-1:0]         m_data_f,
   output logic                 m_valid_f,
   input  logic                 m_ready_f
);

   localparam int NW = $clog2(N);
   localparam int MW = $clog2(M);

   state_e state_q, state_d;
   logic   busy_q, busy_d;
   logic   done_q, done_d;
   logic   ld_ready_q, ld_ready_d;
   logic   go;
   logic   fin_x, fin_f;
   logic   wr_x, wr_f;

   always_comb begin
      state_d = state_q;
      go      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (nframes != 8'd0) begin
                  state_d = SEND;
                  go      = 1'b1;
               end else begin
                  state_d = FIN;
               end
            end
         end
         SEND: begin
            if (fin_x && fin_f) begin
               state_d = FIN;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d     = (state_d == SEND);
      done_d     = (state_d == FIN);
      ld_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ld_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ld_ready_q <= ld_ready_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign ld_ready = ld_ready_q;

   assign wr_x = ld_ready_q & ld_valid & ~ld_sel;
   assign wr_f = ld_ready_q & ld_valid &  ld_sel;

   stream_chan_tx #(.LEN(N), .W(W), .IW(NW)) u_chan_x (
      .clk     (clk),
      .reset_n (reset_n),
      .go      (go),
      .nframes (nframes),
      .wr_en   (wr_x),
      .wr_addr (ld_addr),
      .wr_data (ld_data),
      .m_data  (m_data_x),
      .m_valid (m_valid_x),
      .m_ready (m_ready_x),
      .fin     (fin_x)
   );

   stream_chan_tx #(.LEN(M), .W(W), .IW(MW)) u_chan_f (
      .clk     (clk),
      .reset_n (reset_n),
      .go      (go),
      .nframes (nframes),
      .wr_en   (wr_f),
      .wr_addr (ld_addr[MW-1:0]),
      .wr_data (ld_data),
      .m_data  (m_data_f),
      .m_valid (m_valid_f),
      .m_ready (m_ready_f),
      .fin     (fin_f)
   );

endmodule
